// File: rtl/pe_psum_accumulator.sv
// Partial-sum accumulator for one PE. It holds NUM_CH independent
// accumulators and executes ACCUM, FLUSH and CLEAR commands. A FLUSH adds
// an incoming psum to the selected accumulator, emits the result through a
// valid/ready port and zeroes that accumulator.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | accept commands; ACCUM and CLEAR complete in one cycle
// S_WAIT_PSUM | FLUSH latched; waiting for the psum handshake
// S_OUT       | flush result presented; held until out_ready
module pe_psum_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 10,
    parameter int NUM_CH    = 4,
    parameter int SATURATE  = 1,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CH_W-1:0]      cmd_ch,
    input  logic [WIDTH-1:0]     cmd_data,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    input  logic [ACC_WIDTH-1:0] psum_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 ovf,
    output logic                 err
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_PSUM = 2'd1,
        S_OUT       = 2'd2
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_ACCUM = 2'b01;
    localparam logic [1:0] OP_FLUSH = 2'b10;

    state_t                r_state;
    logic [ACC_WIDTH-1:0]  r_acc [NUM_CH];
    logic [CH_W-1:0]       r_ch;
    logic [ACC_WIDTH-1:0]  r_out_data;
    logic [CH_W-1:0]       r_out_ch;
    logic                  r_out_valid;
    logic                  r_ovf;
    logic                  r_err;

    logic                  w_ch_bad;
    logic [ACC_WIDTH:0]    w_sum_cmd;
    logic [ACC_WIDTH:0]    w_sum_psum;

    // Out-of-range channel or reserved opcode is consumed but flagged.
    function automatic logic [ACC_WIDTH-1:0] clamp(input logic [ACC_WIDTH:0] s);
        if (s[ACC_WIDTH] && (SATURATE != 0)) begin
            return '1;
        end
        return s[ACC_WIDTH-1:0];
    endfunction

    // Readies depend only on state; they are forced low while rst is held.
    always_comb begin
        cmd_ready  = (r_state == S_IDLE) && !rst;
        psum_ready = (r_state == S_WAIT_PSUM) && !rst;
        w_ch_bad   = ({1'b0, cmd_ch} >= (CH_W + 1)'(NUM_CH));
        w_sum_cmd  = {1'b0, r_acc[cmd_ch]} + (ACC_WIDTH + 1)'(cmd_data);
        w_sum_psum = {1'b0, r_acc[r_ch]} + {1'b0, psum_in};
    end

    // Command execution, flush sequencing and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
            r_ch        <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (w_ch_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_ACCUM: begin
                                    r_acc[cmd_ch] <= clamp(w_sum_cmd);
                                    if (w_sum_cmd[ACC_WIDTH]) r_ovf <= 1'b1;
                                end
                                OP_CLEAR: r_acc[cmd_ch] <= '0;
                                OP_FLUSH: begin
                                    r_ch    <= cmd_ch;
                                    r_state <= S_WAIT_PSUM;
                                end
                                default:  r_err <= 1'b1;
                            endcase
                        end
                    end
                end
                S_WAIT_PSUM: begin
                    if (psum_valid) begin
                        r_out_data  <= clamp(w_sum_psum);
                        r_out_ch    <= r_ch;
                        r_acc[r_ch] <= '0;
                        if (w_sum_psum[ACC_WIDTH]) r_ovf <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign ovf       = r_ovf;
    assign err       = r_err;

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Bench for pe_psum_accumulator. Two instances run side by side:
// dut0 uses the defaults (NUM_CH=4, saturating) and dut1 uses NUM_CH=3 with
// wrapping arithmetic, so out-of-range channels and both overflow modes are
// reachable. A transaction-level model per instance predicts every output.
module tb_pe_psum_accumulator;

    localparam int AW   = 10;
    localparam int AMAX = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             c_rst   [2];
    logic             c_valid [2];
    logic [1:0]       c_op    [2];
    logic [1:0]       c_ch    [2];
    logic [7:0]       c_data  [2];
    logic             c_pv    [2];
    logic [AW-1:0]    c_psum  [2];
    logic             c_ordy  [2];

    logic             o_cr    [2];
    logic             o_pr    [2];
    logic             o_ov    [2];
    logic [AW-1:0]    o_data  [2];
    logic [1:0]       o_ch    [2];
    logic             o_ovf   [2];
    logic             o_err   [2];

    pe_psum_accumulator #(.WIDTH(8), .ACC_WIDTH(AW), .NUM_CH(4), .SATURATE(1)) dut0 (
        .clk(clk), .rst(c_rst[0]), .cmd_valid(c_valid[0]), .cmd_ready(o_cr[0]),
        .cmd_op(c_op[0]), .cmd_ch(c_ch[0]), .cmd_data(c_data[0]),
        .psum_valid(c_pv[0]), .psum_ready(o_pr[0]), .psum_in(c_psum[0]),
        .out_valid(o_ov[0]), .out_ready(c_ordy[0]), .out_data(o_data[0]),
        .out_ch(o_ch[0]), .ovf(o_ovf[0]), .err(o_err[0]));

    pe_psum_accumulator #(.WIDTH(8), .ACC_WIDTH(AW), .NUM_CH(3), .SATURATE(0)) dut1 (
        .clk(clk), .rst(c_rst[1]), .cmd_valid(c_valid[1]), .cmd_ready(o_cr[1]),
        .cmd_op(c_op[1]), .cmd_ch(c_ch[1]), .cmd_data(c_data[1]),
        .psum_valid(c_pv[1]), .psum_ready(o_pr[1]), .psum_in(c_psum[1]),
        .out_valid(o_ov[1]), .out_ready(c_ordy[1]), .out_data(o_data[1]),
        .out_ch(o_ch[1]), .ovf(o_ovf[1]), .err(o_err[1]));

    // Model: what each instance is doing (0 idle, 1 awaiting psum, 2 result
    // pending) plus plain integer accumulators.
    int m_phase [2];
    int m_acc   [2][4];
    int m_lch   [2];
    int m_out   [2];
    int m_och   [2];
    int m_ovf   [2];
    int m_err   [2];

    int n_checks = 0;
    int n_errors = 0;

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic add_sat(input int d, input int a, input int b, output int r);
        r = a + b;
        if (r >= AMAX) begin
            m_ovf[d] = 1;
            r = (d == 0) ? AMAX - 1 : r - AMAX;
        end
    endtask

    task automatic model_step(input int d);
        int ch;
        int r;
        if (c_rst[d]) begin
            m_phase[d] = 0;
            for (int i = 0; i < 4; i++) m_acc[d][i] = 0;
            m_lch[d] = 0; m_out[d] = 0; m_och[d] = 0; m_ovf[d] = 0; m_err[d] = 0;
        end else if (m_phase[d] == 0) begin
            if (c_valid[d]) begin
                ch = int'(c_ch[d]);
                if (ch >= nch(d) || c_op[d] == 2'b11) m_err[d] = 1;
                else if (c_op[d] == 2'b01) begin
                    add_sat(d, m_acc[d][ch], int'(c_data[d]), r);
                    m_acc[d][ch] = r;
                end else if (c_op[d] == 2'b00) m_acc[d][ch] = 0;
                else begin
                    m_lch[d] = ch;
                    m_phase[d] = 1;
                end
            end
        end else if (m_phase[d] == 1) begin
            if (c_pv[d]) begin
                add_sat(d, m_acc[d][m_lch[d]], int'(c_psum[d]), r);
                m_out[d] = r;
                m_och[d] = m_lch[d];
                m_acc[d][m_lch[d]] = 0;
                m_phase[d] = 2;
            end
        end else begin
            if (c_ordy[d]) m_phase[d] = 0;
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk("cmd_ready", d, int'(o_cr[d]), int'(m_phase[d] == 0 && !c_rst[d]));
            chk("psum_ready", d, int'(o_pr[d]), int'(m_phase[d] == 1 && !c_rst[d]));
            chk("out_valid", d, int'(o_ov[d]), int'(m_phase[d] == 2));
            chk("out_data", d, int'(o_data[d]), m_out[d]);
            chk("out_ch", d, int'(o_ch[d]), m_och[d]);
            chk("ovf", d, int'(o_ovf[d]), m_ovf[d]);
            chk("err", d, int'(o_err[d]), m_err[d]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [1:0] ch,
                         input int data, input logic pv, input int psum, input logic ordy);
        for (int d = 0; d < 2; d++) begin
            c_valid[d] = v; c_op[d] = op; c_ch[d] = ch; c_data[d] = 8'(data);
            c_pv[d] = pv; c_psum[d] = AW'(psum); c_ordy[d] = ordy;
        end
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 2'd0, 0, 1'b0, 0, 1'b0);
    endtask

    // Literal expectations: pin both the model and the design.
    task automatic expect_lit(input string nm, input int d, input int val, input int mval, input int dval);
        chk({nm, "_model"}, d, mval, val);
        chk(nm, d, dval, val);
    endtask

    task automatic accum(input logic [1:0] ch, input int data);
        drive(1'b1, 2'b01, ch, data, 1'b0, 0, 1'b0);
        tick();
    endtask

    // FLUSH on channel cha (dut0) / chb (dut1) and expect the given results.
    task automatic flush(input logic [1:0] cha, input logic [1:0] chb, input int psum,
                         input int ea, input int eb);
        drive(1'b1, 2'b10, cha, 0, 1'b0, 0, 1'b0);
        c_ch[1] = chb;
        tick();
        drive(1'b0, 2'b00, 2'd0, 0, 1'b1, psum, 1'b0);
        tick();
        expect_lit("flush_valid", 0, 1, int'(m_phase[0] == 2), int'(o_ov[0]));
        expect_lit("flush_data", 0, ea, m_out[0], int'(o_data[0]));
        expect_lit("flush_data", 1, eb, m_out[1], int'(o_data[1]));
        expect_lit("flush_ch", 0, int'(cha), m_och[0], int'(o_ch[0]));
        expect_lit("flush_ch", 1, int'(chb), m_och[1], int'(o_ch[1]));
        drive(1'b0, 2'b00, 2'd0, 0, 1'b0, 0, 1'b1);
        tick();
        idle();
    endtask

    initial begin
        c_rst[0] = 1'b1; c_rst[1] = 1'b1;
        idle();
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            expect_lit("rst_out_valid", d, 0, int'(m_phase[d] == 2), int'(o_ov[d]));
            expect_lit("rst_err", d, 0, m_err[d], int'(o_err[d]));
        end
        c_rst[0] = 1'b0; c_rst[1] = 1'b0;
        tick();
        expect_lit("cmd_ready_after_rst", 0, 1, int'(m_phase[0] == 0), int'(o_cr[0]));

        // Basic accumulate and flush, then an empty flush.
        accum(2'd0, 10); accum(2'd0, 20); accum(2'd0, 30);
        flush(2'd0, 2'd0, 5, 65, 65);
        flush(2'd0, 2'd0, 0, 0, 0);
        expect_lit("ovf_clean", 0, 0, m_ovf[0], int'(o_ovf[0]));

        // Interleaved channels.
        accum(2'd1, 7); accum(2'd2, 3); accum(2'd1, 8);
        flush(2'd1, 2'd1, 0, 15, 15);
        flush(2'd2, 2'd2, 1, 4, 4);
        flush(2'd3, 2'd0, 0, 0, 0);

        // Overflow: dut0 saturates, dut1 wraps.
        for (int i = 0; i < 4; i++) accum(2'd0, 255);
        accum(2'd0, 50);
        expect_lit("ovf_set", 0, 1, m_ovf[0], int'(o_ovf[0]));
        expect_lit("ovf_set", 1, 1, m_ovf[1], int'(o_ovf[1]));
        flush(2'd0, 2'd0, 0, 1023, 46);

        // Backpressure: result held for 5 cycles with out_ready low.
        accum(2'd2, 100);
        drive(1'b1, 2'b10, 2'd2, 0, 1'b0, 0, 1'b0);
        tick();
        drive(1'b0, 2'b00, 2'd0, 0, 1'b1, 7, 1'b0);
        tick();
        drive(1'b1, 2'b01, 2'd1, 9, 1'b1, 3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_lit("bp_data", 0, 107, m_out[0], int'(o_data[0]));
            expect_lit("bp_cmd_ready", 0, 0, int'(m_phase[0] == 0), int'(o_cr[0]));
        end
        drive(1'b0, 2'b00, 2'd0, 0, 1'b0, 0, 1'b1);
        tick();
        expect_lit("bp_released", 0, 0, int'(m_phase[0] == 2), int'(o_ov[0]));
        idle();
        tick();

        // Reset while waiting for psum.
        accum(2'd3, 5);
        drive(1'b1, 2'b10, 2'd3, 0, 1'b0, 0, 1'b0);
        c_ch[1] = 2'd2;
        tick();
        idle();
        c_rst[0] = 1'b1; c_rst[1] = 1'b1;
        tick();
        c_rst[0] = 1'b0; c_rst[1] = 1'b0;
        expect_lit("mid_rst_no_out", 0, 0, int'(m_phase[0] == 2), int'(o_ov[0]));
        tick();
        expect_lit("cmd_ready_post_rst", 0, 1, int'(m_phase[0] == 0), int'(o_cr[0]));
        flush(2'd3, 2'd2, 9, 9, 9);

        // Reserved op and out-of-range channel.
        drive(1'b1, 2'b11, 2'd0, 0, 1'b0, 0, 1'b0);
        c_valid[1] = 1'b0;
        tick();
        drive(1'b1, 2'b01, 2'd3, 12, 1'b0, 0, 1'b0);
        c_valid[0] = 1'b0;
        tick();
        expect_lit("err_reserved", 0, 1, m_err[0], int'(o_err[0]));
        expect_lit("err_range", 1, 1, m_err[1], int'(o_err[1]));
        expect_lit("err_consumed", 1, 1, int'(m_phase[1] == 0), int'(o_cr[1]));
        accum(2'd0, 12);
        drive(1'b1, 2'b00, 2'd0, 0, 1'b0, 0, 1'b0);
        tick();
        flush(2'd0, 2'd0, 0, 0, 0);

        // Randomized traffic, independent per instance.
        for (int n = 0; n < 4000; n++) begin
            for (int d = 0; d < 2; d++) begin
                c_rst[d]   = ($urandom_range(0, 299) == 0);
                c_valid[d] = ($urandom_range(0, 9) < 7);
                c_op[d]    = ($urandom_range(0, 9) < 6) ? 2'b01 : 2'($urandom_range(0, 3));
                c_ch[d]    = 2'($urandom_range(0, 3));
                c_data[d]  = 8'($urandom);
                c_pv[d]    = $urandom_range(0, 1) == 1;
                c_psum[d]  = AW'($urandom);
                c_ordy[d]  = ($urandom_range(0, 9) < 6);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
